// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - 16x oversampled UART receiver, 8 data bits, parity, one stop bit
module uart_rx_fsm #(
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       sample_tick,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int              TW    = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   HALF  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]   LAST  = TW'(OVERSAMPLE - 1);
    localparam logic            P_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tick_cnt, tick_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            perr, perr_nxt;
    logic [7:0]      data_nxt;
    logic            valid_nxt, perr_out_nxt, ferr_nxt;
    logic            sync1, rx_s;
    logic [1:0]      sync_fill;
    logic            armed;

    // rx_s holds its reset value for two clocks; only a genuinely observed
    // high line arms start detection, so a line stuck low after reset is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            sync_fill  <= 2'b00;
            armed      <= 1'b0;
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rx_in;
            rx_s       <= sync1;
            sync_fill  <= {sync_fill[0], 1'b1};
            armed      <= armed | (sample_tick & sync_fill[1] & rx_s);
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            bit_cnt    <= bit_nxt;
            shift      <= shift_nxt;
            perr       <= perr_nxt;
            rx_data    <= data_nxt;
            rx_valid   <= valid_nxt;
            parity_err <= perr_out_nxt;
            frame_err  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tick_nxt     = tick_cnt;
        bit_nxt      = bit_cnt;
        shift_nxt    = shift;
        perr_nxt     = perr;
        data_nxt     = rx_data;
        valid_nxt    = 1'b0;
        perr_out_nxt = parity_err;
        ferr_nxt     = frame_err;
        if (sample_tick) begin
            if (state != IDLE) begin
                tick_nxt = tick_cnt + TW'(1);
            end
            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == HALF) begin
                        tick_nxt  = '0;
                        bit_nxt   = '0;
                        state_nxt = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick_cnt == LAST) begin
                        shift_nxt = {rx_s, shift[7:1]};
                        bit_nxt   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nxt = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (tick_cnt == LAST) begin
                        perr_nxt  = ((^shift) ^ rx_s) != P_ODD;
                        state_nxt = STOP;
                    end
                end
                STOP: begin
                    if (tick_cnt == LAST) begin
                        data_nxt     = shift;
                        perr_out_nxt = perr;
                        ferr_nxt     = ~rx_s;
                        valid_nxt    = 1'b1;
                        state_nxt    = rx_s ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - directed bench for uart_rx_fsm, even and odd parity instances
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_in = 1'b1;
    logic       sample_tick = 1'b0;
    logic [7:0] rx_data, o_data;
    logic       rx_valid, parity_err, frame_err, rx_busy;
    logic       o_valid, o_perr, o_ferr, o_busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int vcnt = 0;
    int ocnt = 0;
    int last_cyc = 0;
    int prev_cyc = 0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_pe = 1'b0;
    logic       cap_fe = 1'b0;
    logic       cap_ope = 1'b0;

    uart_rx_fsm u_dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .sample_tick(sample_tick),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .rx_busy(rx_busy)
    );

    uart_rx_fsm #(.PARITY_ODD(1)) u_odd (
        .clk(clk), .reset(reset), .rx_in(rx_in), .sample_tick(sample_tick),
        .rx_data(o_data), .rx_valid(o_valid), .parity_err(o_perr),
        .frame_err(o_ferr), .rx_busy(o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt     = vcnt + 1;
            cap_data = rx_data;
            cap_pe   = parity_err;
            cap_fe   = frame_err;
            prev_cyc = last_cyc;
            last_cyc = cyc;
        end
        if (o_valid) begin
            ocnt    = ocnt + 1;
            cap_ope = o_perr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line_bit(input logic b);
        rx_in = b;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        line_bit(p);
        line_bit(s);
    endtask

    task automatic chk_frame(input string tag, input int n0, input logic [7:0] d,
                             input logic pe, input logic fe, input logic ope);
        chk({tag, "_count"}, vcnt, n0 + 1);
        chk({tag, "_data"}, cap_data, d);
        chk({tag, "_perr"}, cap_pe, pe);
        chk({tag, "_ferr"}, cap_fe, fe);
        chk({tag, "_odd_count"}, ocnt, n0 + 1);
        chk({tag, "_odd_perr"}, cap_ope, ope);
    endtask

    initial begin
        int n;
        repeat (5) @(negedge clk);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        reset = 1'b1;
        repeat (128) @(negedge clk);

        n = vcnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        chk_frame("a5", n, 8'hA5, 1'b0, 1'b0, 1'b1);
        chk("a5_busy_after_stop", rx_busy, 1'b0);

        n = vcnt;
        send_frame(8'h3C, 1'b1, 1'b1);
        chk_frame("3c", n, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("3c_flag_held", parity_err, 1'b1);

        n = vcnt;
        send_frame(8'h01, 1'b1, 1'b1);
        chk_frame("01", n, 8'h01, 1'b0, 1'b0, 1'b1);

        n = vcnt;
        rx_in = 1'b0;
        repeat (16) @(negedge clk);
        rx_in = 1'b1;
        repeat (128) @(negedge clk);
        chk("glitch_count", vcnt, n);
        chk("glitch_busy", rx_busy, 1'b0);
        chk("glitch_data", rx_data, 8'h01);

        n = vcnt;
        send_frame(8'h55, 1'b0, 1'b0);
        chk_frame("55", n, 8'h55, 1'b0, 1'b1, 1'b1);
        repeat (192) @(negedge clk);
        chk("break_busy", rx_busy, 1'b1);
        chk("break_count", vcnt, n + 1);
        rx_in = 1'b1;
        repeat (64) @(negedge clk);
        chk("break_idle", rx_busy, 1'b0);

        n = vcnt;
        send_frame(8'h12, 1'b0, 1'b1);
        chk_frame("12", n, 8'h12, 1'b0, 1'b0, 1'b1);
        repeat (64) @(negedge clk);

        n = vcnt;
        send_frame(8'h00, 1'b0, 1'b1);
        chk_frame("b2b0", n, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        chk_frame("b2b1", n + 1, 8'hFF, 1'b0, 1'b0, 1'b1);
        chk("b2b_spacing", last_cyc - prev_cyc, 704);
        repeat (64) @(negedge clk);

        n = vcnt;
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(1'b0);
        rx_in = 1'b1;
        repeat (32) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_valid", rx_valid, 1'b0);
        chk("midrst_perr", parity_err, 1'b0);
        chk("midrst_ferr", frame_err, 1'b0);
        chk("midrst_busy", rx_busy, 1'b0);
        reset = 1'b1;
        repeat (640) @(negedge clk);
        chk("abort_count", vcnt, n);
        chk("abort_busy", rx_busy, 1'b0);

        n = vcnt;
        send_frame(8'h81, 1'b0, 1'b1);
        chk_frame("81", n, 8'h81, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
